parity_tx: RTL

Serial parity transmitter: accepts a parallel DATA_W-bit word through a ready/load handshake and shifts it out LSB-first on a one-bit serial line, followed by one parity bit. It is the transmit end of the serial parity link. Its output x feeds the running-parity checker directly; `frame` and `last` mark the valid bits and the parity bit.

---
 rtl/parity_tx.sv | 66 ++++++
 1 files changed

// File: rtl/parity_tx.sv
// parity_tx: LSB-first serial transmitter that appends one parity bit to each DATA_W-bit word.
// Define PARITY_ODD_EN for odd parity; the default build sends even parity.
module parity_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  output logic              ready,
  output logic              x,
  output logic              frame,
  output logic              last
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] PAR  = 2'd2;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);
  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic              par;
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (state_q == IDLE && load) begin
      state_d = DATA;
      sh_d    = din;
      cnt_d   = '0;
      acc_d   = 1'b0;
    end else if (state_q == DATA) begin
      sh_d    = sh_q >> 1;
      acc_d   = acc_q ^ sh_q[0];
      cnt_d   = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
      state_d = (cnt_q == CNT_LAST) ? PAR : DATA;
    end else if (state_q != IDLE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end
`ifdef PARITY_ODD_EN
  assign par = ~acc_q;
`else
  assign par = acc_q;
`endif
  assign ready = (state_q == IDLE);
  assign frame = (state_q == DATA) || (state_q == PAR);
  assign last  = (state_q == PAR);
  assign x     = (state_q == DATA) ? sh_q[0] : (state_q == PAR) ? par : 1'b0;
endmodule
